fb_line_fetcher: RTL and testbench

Prefetch controller and memory arbiter for the 50×50 framebuffer window. During horizontal blanking it sequences 50 word reads of the next image row from the shared data memory into a local line buffer, so the pixel path never touches memory during active video. It arbitrates the single data-memory port between the CPU and this fetch engine; the fetch engine has priority and stalls the CPU while active. It sits between the single-cycle CPU's data port, the data memory and the pixel generator.

---
 rtl/fb_pkg.sv | 17 +
 rtl/fb_line_fetcher_if.sv | 12 +
 rtl/fb_line_buffer.sv | 18 +
 rtl/fb_line_fetcher.sv | 87 ++++++++
 tb/tb_fb_line_fetcher.sv | 246 ++++++++++++++++++++++++
 5 files changed

// File: rtl/fb_pkg.sv
// Framebuffer window geometry and shared types for the line fetch engine.
package fb_pkg;
    typedef enum logic {IDLE, FETCH} fetch_state_t;

    localparam int unsigned IMG_X0   = 200;
    localparam int unsigned IMG_Y0   = 200;
    localparam int unsigned IMG_W    = 50;
    localparam int unsigned IMG_H    = 50;
    localparam int unsigned TRIG_X   = 640;
    localparam logic [31:0] FB_BASE  = 32'd0;
    localparam int unsigned FB_WORDS = IMG_W * IMG_H;

    // Byte address of image word (row, col).
    function automatic logic [31:0] word_addr(input logic [5:0] row, input logic [5:0] col);
        return FB_BASE + ((32'(row) * IMG_W + 32'(col)) << 2);
    endfunction
endpackage

// File: rtl/fb_line_fetcher_if.sv
// Simple word bus used for both the CPU data port and the data-memory port.
interface fb_line_fetcher_if;
    logic        req;
    logic        we;
    logic [31:0] adr;
    logic [31:0] wdata;
    logic [31:0] rdata;
    logic        stall;

    modport master (output req, we, adr, wdata, input rdata, stall);
    modport slave  (input req, we, adr, wdata, output rdata, stall);
endinterface

// File: rtl/fb_line_buffer.sv
// 64x8 line store: one synchronous write port, one combinational read port.
module fb_line_buffer (
    input  logic       clk,
    input  logic       we,
    input  logic [5:0] waddr,
    input  logic [7:0] wdata,
    input  logic [5:0] raddr,
    output logic [7:0] rdata
);
    logic [7:0] mem [0:63];

    // Contents deliberately survive reset.
    always_ff @(posedge clk) begin
        if (we) mem[waddr] <= wdata;
    end

    assign rdata = mem[raddr];
endmodule

// File: rtl/fb_line_fetcher.sv
// Prefetches the next image row into a line buffer during blanking and
// arbitrates the data-memory port, giving the fetch priority over the CPU.
module fb_line_fetcher
    import fb_pkg::*;
(
    input  logic               clk,
    input  logic               reset,
    input  logic [9:0]         x,
    input  logic [9:0]         y,
    fb_line_fetcher_if.slave   cpu,
    fb_line_fetcher_if.master  mem,
    input  logic [5:0]         pix_idx,
    output logic [7:0]         pix_data,
    output logic               line_valid
);
    fetch_state_t state, state_nxt;
    logic [5:0]   row, cnt;
    logic [10:0]  y1, roff;
    logic         trig, last, buf_we;
    logic [7:0]   buf_rd;

    // Row fetched on this line is the one displayed on the next line.
    assign y1   = {1'b0, y} + 11'd1;
    assign roff = y1 - 11'(IMG_Y0);
    assign trig = (x == 10'(TRIG_X)) && (y1 >= 11'(IMG_Y0)) && (roff < 11'(IMG_H));
    assign last = (cnt == 6'(IMG_W - 1));

    always_ff @(posedge clk or posedge reset) begin
        if (reset) state <= IDLE;
        else       state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        mem.req   = cpu.req;
        mem.we    = cpu.we & cpu.req;
        mem.adr   = cpu.adr;
        mem.wdata = cpu.wdata;
        cpu.rdata = mem.rdata;
        cpu.stall = 1'b0;
        buf_we    = 1'b0;
        case (state)
            IDLE: begin
                if (trig) state_nxt = FETCH;
            end
            FETCH: begin
                mem.req   = 1'b1;
                mem.we    = 1'b0;
                mem.adr   = word_addr(row, cnt);
                cpu.rdata = 32'd0;
                cpu.stall = cpu.req;
                buf_we    = 1'b1;
                if (last) state_nxt = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            row        <= 6'd0;
            cnt        <= 6'd0;
            line_valid <= 1'b0;
        end else begin
            if (state == IDLE && trig) begin
                row        <= roff[5:0];
                cnt        <= 6'd0;
                line_valid <= 1'b0;
            end else if (state == FETCH) begin
                cnt <= last ? 6'd0 : cnt + 6'd1;
                if (last) line_valid <= 1'b1;
            end
            // Drop validity once the scan leaves the image rows.
            if (y == 10'(IMG_Y0 + IMG_H) && x == 10'd0) line_valid <= 1'b0;
        end
    end

    fb_line_buffer u_buf (
        .clk   (clk),
        .we    (buf_we),
        .waddr (cnt),
        .wdata (mem.rdata[7:0]),
        .raddr (pix_idx),
        .rdata (buf_rd)
    );

    assign pix_data = (pix_idx < 6'(IMG_W)) ? buf_rd : 8'd0;
endmodule

// File: tb/tb_fb_line_fetcher.sv
// Randomized bench for fb_line_fetcher against a behavioural scan/memory model.
module tb_fb_line_fetcher;
    import fb_pkg::*;

    logic        clk = 1'b0;
    logic        reset;
    logic [9:0]  x, y;
    logic [5:0]  pix_idx;
    logic [7:0]  pix_data;
    logic        line_valid;
    logic [31:0] mem [0:16383];
    int          total = 0;
    int          bad = 0;

    fb_line_fetcher_if cpu_bus();
    fb_line_fetcher_if mem_bus();

    always #5 clk = ~clk;

    assign mem_bus.rdata = mem[mem_bus.adr[15:2]];
    assign mem_bus.stall = 1'b0;

    fb_line_fetcher dut (
        .clk        (clk),
        .reset      (reset),
        .x          (x),
        .y          (y),
        .cpu        (cpu_bus),
        .mem        (mem_bus),
        .pix_idx    (pix_idx),
        .pix_data   (pix_data),
        .line_valid (line_valid)
    );

    function automatic logic [31:0] fb_word(input int row, input int col);
        return FB_BASE + 32'(4 * (row * int'(IMG_W) + col));
    endfunction

    // Advance one clock; the memory model commits a write seen before the edge.
    task automatic step();
        logic        w;
        logic [31:0] a, d;
        w = mem_bus.we;
        a = mem_bus.adr;
        d = mem_bus.wdata;
        @(posedge clk);
        if (w) mem[a[15:2]] = d;
        #1;
    endtask

    task automatic rand_cpu();
        cpu_bus.req   = 1'($urandom_range(0, 1));
        cpu_bus.we    = 1'($urandom_range(0, 1));
        cpu_bus.adr   = 32'h8000 + 32'($urandom_range(0, 1023) << 2);
        cpu_bus.wdata = $urandom;
    endtask

    task automatic fill_random();
        for (int k = 0; k < int'(FB_WORDS); k++) mem[k] = $urandom;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        x = 10'd0; y = 10'd0; pix_idx = 6'd0;
        cpu_bus.req = 1'b1; cpu_bus.we = 1'b1;
        cpu_bus.adr = 32'h8010; cpu_bus.wdata = 32'hdead_beef;
        mem[32'h8010 >> 2] = 32'h1234_5678;
        repeat (3) @(posedge clk);
        #2;
        total++; if (line_valid !== 1'b0) begin bad++; $display("FAIL reset_lv: got %b want 0", line_valid); end
        total++; if (cpu_bus.stall !== 1'b0) begin bad++; $display("FAIL reset_stall: got %b want 0", cpu_bus.stall); end
        total++; if (mem_bus.adr !== 32'h8010) begin bad++; $display("FAIL reset_adr: got %h want 8010", mem_bus.adr); end
        total++; if (mem_bus.we !== 1'b1) begin bad++; $display("FAIL reset_we: got %b want 1", mem_bus.we); end
        total++; if (cpu_bus.rdata !== 32'h1234_5678) begin bad++; $display("FAIL reset_rdata: got %h want 12345678", cpu_bus.rdata); end
        cpu_bus.req = 1'b0; cpu_bus.we = 1'b0;
        @(posedge clk); #1;
        reset = 1'b0;
        #1;
    endtask

    task automatic test_fetch_timing();
        for (int k = 0; k < int'(FB_WORDS); k++) mem[k] = 32'(k + 1);
        cpu_bus.req = 1'b0;
        for (int xx = 630; xx <= 700; xx++) begin
            step();
            x = 10'(xx); y = 10'd199;
            #1;
            if (xx >= 641 && xx <= 690) begin
                total++; if (mem_bus.adr !== 32'(4 * (xx - 641))) begin bad++; $display("FAIL timing_adr x=%0d: got %0d want %0d", xx, mem_bus.adr, 4 * (xx - 641)); end
                total++; if (mem_bus.we !== 1'b0) begin bad++; $display("FAIL timing_we x=%0d: got %b want 0", xx, mem_bus.we); end
                total++; if (line_valid !== 1'b0) begin bad++; $display("FAIL timing_lv_low x=%0d: got %b want 0", xx, line_valid); end
            end else begin
                total++; if (line_valid !== (xx >= 691)) begin bad++; $display("FAIL timing_lv x=%0d: got %b want %b", xx, line_valid, xx >= 691); end
            end
        end
        for (int i = 0; i < 64; i++) begin
            pix_idx = 6'(i);
            #1;
            total++; if (pix_data !== ((i < int'(IMG_W)) ? 8'(i + 1) : 8'd0)) begin bad++; $display("FAIL timing_pix idx=%0d: got %0d want %0d", i, pix_data, (i < int'(IMG_W)) ? i + 1 : 0); end
        end
    endtask

    task automatic test_arbitration();
        logic [31:0] wd;
        wd = $urandom;
        cpu_bus.req = 1'b0; cpu_bus.we = 1'b0;
        for (int xx = 630; xx <= 695; xx++) begin
            step();
            x = 10'(xx); y = 10'd199;
            if (xx == 650) begin
                cpu_bus.req = 1'b1; cpu_bus.we = 1'b1; cpu_bus.adr = 32'h400; cpu_bus.wdata = wd;
            end
            if (xx == 692) begin cpu_bus.req = 1'b0; cpu_bus.we = 1'b0; end
            #1;
            if (xx >= 650 && xx <= 690) begin
                total++; if (cpu_bus.stall !== 1'b1) begin bad++; $display("FAIL arb_stall x=%0d: got %b want 1", xx, cpu_bus.stall); end
                total++; if (mem_bus.we !== 1'b0) begin bad++; $display("FAIL arb_we x=%0d: got %b want 0", xx, mem_bus.we); end
                total++; if (cpu_bus.rdata !== 32'd0) begin bad++; $display("FAIL arb_rdata x=%0d: got %h want 0", xx, cpu_bus.rdata); end
            end
            if (xx == 691) begin
                total++; if (cpu_bus.stall !== 1'b0) begin bad++; $display("FAIL arb_release: got %b want 0", cpu_bus.stall); end
                total++; if (mem_bus.we !== 1'b1) begin bad++; $display("FAIL arb_grant_we: got %b want 1", mem_bus.we); end
                total++; if (mem_bus.adr !== 32'h400) begin bad++; $display("FAIL arb_grant_adr: got %h want 400", mem_bus.adr); end
                total++; if (mem_bus.wdata !== wd) begin bad++; $display("FAIL arb_grant_wdata: got %h want %h", mem_bus.wdata, wd); end
            end
        end
        total++; if (mem[32'h400 >> 2] !== wd) begin bad++; $display("FAIL arb_landed: got %h want %h", mem[32'h400 >> 2], wd); end
    endtask

    task automatic test_row_addr();
        int          n;
        logic [31:0] first, last;
        logic [7:0]  want;
        fill_random();
        n = 0; first = '1; last = '1;
        for (int xx = 630; xx <= 700; xx++) begin
            step();
            x = 10'(xx); y = 10'd248;
            rand_cpu();
            #1;
            if (xx >= 641 && xx <= 690) begin
                n++;
                if (xx == 641) first = mem_bus.adr;
                last = mem_bus.adr;
                total++; if (mem_bus.adr !== fb_word(49, xx - 641)) begin bad++; $display("FAIL row_adr x=%0d: got %0d want %0d", xx, mem_bus.adr, fb_word(49, xx - 641)); end
                total++; if (cpu_bus.stall !== cpu_bus.req) begin bad++; $display("FAIL row_stall x=%0d: got %b want %b", xx, cpu_bus.stall, cpu_bus.req); end
                total++; if (mem_bus.we !== 1'b0) begin bad++; $display("FAIL row_we x=%0d: got %b want 0", xx, mem_bus.we); end
            end else begin
                total++; if (cpu_bus.stall !== 1'b0) begin bad++; $display("FAIL row_idle_stall x=%0d: got %b want 0", xx, cpu_bus.stall); end
                total++; if (mem_bus.adr !== cpu_bus.adr) begin bad++; $display("FAIL row_idle_adr x=%0d: got %h want %h", xx, mem_bus.adr, cpu_bus.adr); end
                total++; if (mem_bus.we !== (cpu_bus.req & cpu_bus.we)) begin bad++; $display("FAIL row_idle_we x=%0d: got %b want %b", xx, mem_bus.we, cpu_bus.req & cpu_bus.we); end
                total++; if (cpu_bus.rdata !== mem[cpu_bus.adr[15:2]]) begin bad++; $display("FAIL row_idle_rdata x=%0d: got %h want %h", xx, cpu_bus.rdata, mem[cpu_bus.adr[15:2]]); end
            end
        end
        cpu_bus.req = 1'b0; cpu_bus.we = 1'b0;
        total++; if (first !== 32'd9800) begin bad++; $display("FAIL row_first: got %0d want 9800", first); end
        total++; if (last !== 32'd9996) begin bad++; $display("FAIL row_last: got %0d want 9996", last); end
        total++; if (n != 50) begin bad++; $display("FAIL row_count: got %0d want 50", n); end
        total++; if (line_valid !== 1'b1) begin bad++; $display("FAIL row_lv: got %b want 1", line_valid); end
        for (int i = 0; i < 64; i++) begin
            pix_idx = 6'(i);
            #1;
            want = (i < int'(IMG_W)) ? mem[49 * IMG_W + i][7:0] : 8'd0;
            total++; if (pix_data !== want) begin bad++; $display("FAIL row_pix idx=%0d: got %h want %h", i, pix_data, want); end
        end
    endtask

    task automatic test_out_of_range();
        for (int pass = 0; pass < 2; pass++) begin
            for (int xx = 630; xx <= 700; xx++) begin
                step();
                x = 10'(xx); y = (pass == 0) ? 10'd249 : 10'd524;
                rand_cpu();
                #1;
                total++; if (cpu_bus.stall !== 1'b0) begin bad++; $display("FAIL oor_stall y=%0d x=%0d: got %b want 0", y, xx, cpu_bus.stall); end
                total++; if (mem_bus.adr !== cpu_bus.adr) begin bad++; $display("FAIL oor_adr y=%0d x=%0d: got %h want %h", y, xx, mem_bus.adr, cpu_bus.adr); end
            end
            cpu_bus.req = 1'b0; cpu_bus.we = 1'b0;
            if (pass == 0) begin
                total++; if (line_valid !== 1'b1) begin bad++; $display("FAIL oor_lv_hold: got %b want 1", line_valid); end
                step(); x = 10'd0; y = 10'd250;
                step(); x = 10'd1;
                #1;
                total++; if (line_valid !== 1'b0) begin bad++; $display("FAIL oor_lv_clear: got %b want 0", line_valid); end
            end else begin
                total++; if (line_valid !== 1'b0) begin bad++; $display("FAIL oor_lv_524: got %b want 0", line_valid); end
            end
        end
    endtask

    task automatic test_reset_mid();
        int         n;
        logic [7:0] want;
        fill_random();
        cpu_bus.req = 1'b1; cpu_bus.we = 1'b0; cpu_bus.adr = 32'h8020;
        for (int xx = 630; xx <= 700; xx++) begin
            step();
            if (xx == 661) reset = 1'b0;
            x = 10'(xx); y = 10'd199;
            #1;
            if (xx == 660) begin
                total++; if (cpu_bus.stall !== 1'b1) begin bad++; $display("FAIL rmid_pre_stall: got %b want 1", cpu_bus.stall); end
                reset = 1'b1;
                #1;
                total++; if (cpu_bus.stall !== 1'b0) begin bad++; $display("FAIL rmid_stall: got %b want 0", cpu_bus.stall); end
                total++; if (mem_bus.adr !== 32'h8020) begin bad++; $display("FAIL rmid_adr: got %h want 8020", mem_bus.adr); end
            end
            if (xx >= 660) begin
                total++; if (line_valid !== 1'b0) begin bad++; $display("FAIL rmid_lv x=%0d: got %b want 0", xx, line_valid); end
            end
            if (xx > 660) begin
                total++; if (cpu_bus.stall !== 1'b0) begin bad++; $display("FAIL rmid_after x=%0d: got %b want 0", xx, cpu_bus.stall); end
            end
        end
        n = 0;
        for (int xx = 630; xx <= 700; xx++) begin
            step();
            x = 10'(xx); y = 10'd200;
            #1;
            if (cpu_bus.stall === 1'b1) begin
                n++;
                total++; if (mem_bus.adr !== fb_word(1, xx - 641)) begin bad++; $display("FAIL rmid_refetch_adr x=%0d: got %0d want %0d", xx, mem_bus.adr, fb_word(1, xx - 641)); end
            end
        end
        cpu_bus.req = 1'b0;
        total++; if (n != 50) begin bad++; $display("FAIL rmid_refetch_len: got %0d want 50", n); end
        total++; if (line_valid !== 1'b1) begin bad++; $display("FAIL rmid_refetch_lv: got %b want 1", line_valid); end
        for (int i = 0; i < int'(IMG_W); i += 7) begin
            pix_idx = 6'(i);
            #1;
            want = mem[IMG_W + i][7:0];
            total++; if (pix_data !== want) begin bad++; $display("FAIL rmid_pix idx=%0d: got %h want %h", i, pix_data, want); end
        end
    endtask

    initial begin
        test_reset();
        test_fetch_timing();
        test_arbitration();
        test_row_addr();
        test_out_of_range();
        test_reset_mid();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
